// File: rtl/led_shift_out_if.sv
// Bundles the LED value input and the 74HC595-style serial outputs of led_shift_out.
// master is the serialiser side, slave is whoever supplies LED_IN and watches the outputs.
interface led_shift_out_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] LED_IN;
    logic             SCLK;
    logic             SDATA;
    logic             LATCH;
    logic             BUSY;
    logic             DONE;

    modport master (
        input  LED_IN,
        output SCLK,
        output SDATA,
        output LATCH,
        output BUSY,
        output DONE
    );

    modport slave (
        output LED_IN,
        input  SCLK,
        input  SDATA,
        input  LATCH,
        input  BUSY,
        input  DONE
    );
endinterface

// File: rtl/led_shift_out.sv
// Serialises the LED value onto an external shift register (SCLK/SDATA/LATCH),
// sending once after reset and again whenever LED_IN differs from the last frame.
module led_shift_out #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             RST,
    led_shift_out_if.master  bus
);
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_ST
    } state_t;

    state_t           state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [CNT_W-1:0] bit_cnt, bit_n;
    logic [WIDTH-1:0] shift_reg, shift_n;
    logic [WIDTH-1:0] last_sent, last_n;
    logic             force_send, force_n;
    logic             sclk_q, sdata_q, latch_q, busy_q, done_q;
    logic             sclk_n, sdata_n, latch_n, busy_n, done_n;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            last_sent  <= '0;
            force_send <= 1'b1;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            latch_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            last_sent  <= last_n;
            force_send <= force_n;
            sclk_q     <= sclk_n;
            sdata_q    <= sdata_n;
            latch_q    <= latch_n;
            busy_q     <= busy_n;
            done_q     <= done_n;
        end
    end

    // Outputs are derived from the next state so they are registered yet line up
    // with the state they describe; the first data bit appears with BUSY.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shift_n = shift_reg;
        last_n  = last_sent;
        force_n = force_send;

        case (state)
            IDLE: begin
                if (force_send || (bus.LED_IN != last_sent)) begin
                    shift_n = bus.LED_IN;
                    last_n  = bus.LED_IN;
                    force_n = 1'b0;
                    bit_n   = '0;
                    div_n   = '0;
                    state_n = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    state_n = SHIFT_HI;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            SHIFT_HI: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    shift_n = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);
                    bit_n   = bit_cnt + CNT_W'(1);
                    state_n = (bit_cnt == BIT_LAST) ? LATCH_ST : SHIFT_LO;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            LATCH_ST: begin
                if (div_cnt == DIV_LAST) begin
                    div_n   = '0;
                    state_n = IDLE;
                end else begin
                    div_n = div_cnt + DIV_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n  = (state_n != IDLE);
        sclk_n  = (state_n == SHIFT_HI);
        latch_n = (state_n == LATCH_ST);
        done_n  = (state == LATCH_ST) && (state_n == IDLE);
        sdata_n = 1'b0;
        if ((state_n == SHIFT_LO) || (state_n == SHIFT_HI)) begin
            sdata_n = (MSB_FIRST != 0) ? shift_n[WIDTH-1] : shift_n[0];
        end
    end

    assign bus.SCLK  = sclk_q;
    assign bus.SDATA = sdata_q;
    assign bus.LATCH = latch_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
endmodule

// File: tb/tb_led_shift_out.sv
// Directed bench for led_shift_out: a default instance (MSB first, CLK_DIV=4) and
// an LSB-first, CLK_DIV=1 instance, with frames decoded from the serial pins.
module tb_led_shift_out;
    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    int   checks = 0;
    int   errors = 0;

    led_shift_out_if #(.WIDTH(8)) bus_a ();
    led_shift_out_if #(.WIDTH(8)) bus_b ();

    led_shift_out #(.WIDTH(8), .CLK_DIV(4), .MSB_FIRST(1)) dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (bus_a.master)
    );

    led_shift_out #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(0)) dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (bus_b.master)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before the sequence ended");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [7:0] value);
        if (sel == 0) bus_a.LED_IN = value;
        else          bus_b.LED_IN = value;
    endtask

    task automatic sampleOutputs(input int sel, output logic sclk, output logic sdata,
                                 output logic latch, output logic busy, output logic done);
        if (sel == 0) begin
            sclk = bus_a.SCLK; sdata = bus_a.SDATA; latch = bus_a.LATCH;
            busy = bus_a.BUSY; done = bus_a.DONE;
        end else begin
            sclk = bus_b.SCLK; sdata = bus_b.SDATA; latch = bus_b.LATCH;
            busy = bus_b.BUSY; done = bus_b.DONE;
        end
    endtask

    // Called at a falling edge; returns at the first falling edge where BUSY is low again.
    task automatic captureFrame(input int sel, output logic [7:0] bits, output int rises,
                                output int busy_cyc, output int latch_cyc,
                                output int hi_min, output int hi_max,
                                output int lo_min, output int lo_max,
                                output int done_seen, output int timeout);
        logic sclk, sdata, latch, busy, done, prev_sclk;
        int   cur_hi, cur_lo, guard;
        bits = '0; rises = 0; busy_cyc = 0; latch_cyc = 0;
        hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
        done_seen = 0; timeout = 0; prev_sclk = 1'b0; cur_hi = 0; cur_lo = 0;
        guard = 0;
        sampleOutputs(sel, sclk, sdata, latch, busy, done);
        while (!busy && guard < 200) begin
            @(negedge clk);
            guard++;
            sampleOutputs(sel, sclk, sdata, latch, busy, done);
        end
        if (!busy) begin
            timeout = 1;
            return;
        end
        guard = 0;
        while (busy && guard < 400) begin
            busy_cyc++;
            if (latch) latch_cyc++;
            if (done) done_seen++;
            if (sclk && !prev_sclk) begin
                rises++;
                bits = {bits[6:0], sdata};
                if (cur_lo > 0) begin
                    if (cur_lo < lo_min) lo_min = cur_lo;
                    if (cur_lo > lo_max) lo_max = cur_lo;
                end
                cur_lo = 0;
            end
            if (!sclk && prev_sclk) begin
                if (cur_hi < hi_min) hi_min = cur_hi;
                if (cur_hi > hi_max) hi_max = cur_hi;
                cur_hi = 0;
            end
            if (sclk) cur_hi++;
            else if (!latch) cur_lo++;
            prev_sclk = sclk;
            @(negedge clk);
            guard++;
            sampleOutputs(sel, sclk, sdata, latch, busy, done);
        end
        if (busy) timeout = 1;
        if (done) done_seen++;
    endtask

    task automatic idleWindow(input int sel, input int cycles, output int active, output int dones);
        logic sclk, sdata, latch, busy, done;
        active = 0;
        dones  = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            sampleOutputs(sel, sclk, sdata, latch, busy, done);
            if (sclk || latch || busy) active++;
            if (done) dones++;
        end
    endtask

    initial begin
        logic [7:0] bits;
        int rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout;
        int active, dones, guard;
        logic sclk, sdata, latch, busy, done, prev_sclk;
        logic latch_during_abort;

        // Test 1: reset with LED_IN=0, then the forced all-zero frame.
        applyStimulus(0, 8'h00);
        applyStimulus(1, 8'h01);
        repeat (3) @(negedge clk);
        checkOutput("rst_outputs_a", {27'd0, bus_a.SCLK, bus_a.SDATA, bus_a.LATCH, bus_a.BUSY, bus_a.DONE}, 32'd0);
        checkOutput("rst_outputs_b", {27'd0, bus_b.SCLK, bus_b.SDATA, bus_b.LATCH, bus_b.BUSY, bus_b.DONE}, 32'd0);
        rst_a = 1'b0;
        captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t1_timeout", timeout, 0);
        checkOutput("t1_bits", bits, 8'h00);
        checkOutput("t1_rises", rises, 8);
        checkOutput("t1_busy", busy_cyc, 68);
        checkOutput("t1_latch", latch_cyc, 4);
        checkOutput("t1_done", done_seen, 1);
        idleWindow(0, 30, active, dones);
        checkOutput("t1_idle_active", active, 0);
        checkOutput("t1_idle_done", dones, 0);

        // Test 2: 0x00 -> 0xA5 while idle.
        applyStimulus(0, 8'hA5);
        captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t2_timeout", timeout, 0);
        checkOutput("t2_bits", bits, 8'hA5);
        checkOutput("t2_rises", rises, 8);
        checkOutput("t2_hi_min", hi_min, 4);
        checkOutput("t2_hi_max", hi_max, 4);
        checkOutput("t2_lo_min", lo_min, 4);
        checkOutput("t2_lo_max", lo_max, 4);
        checkOutput("t2_latch", latch_cyc, 4);
        checkOutput("t2_done", done_seen, 1);
        idleWindow(0, 10, active, dones);
        checkOutput("t2_idle_active", active, 0);

        // Test 3: LED_IN steps 0x11 then 0x22 while 0x3C is shifting.
        applyStimulus(0, 8'h3C);
        fork
            captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
            begin
                repeat (26) @(negedge clk);
                applyStimulus(0, 8'h11);
                repeat (8) @(negedge clk);
                applyStimulus(0, 8'h22);
            end
        join
        checkOutput("t3_timeout", timeout, 0);
        checkOutput("t3_bits_3c", bits, 8'h3C);
        checkOutput("t3_busy_3c", busy_cyc, 68);
        checkOutput("t3_done_3c", done_seen, 1);
        @(negedge clk);
        checkOutput("t3_gap_busy", bus_a.BUSY, 1'b1);
        captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t3_timeout2", timeout, 0);
        checkOutput("t3_bits_22", bits, 8'h22);
        checkOutput("t3_busy_22", busy_cyc, 68);
        idleWindow(0, 100, active, dones);
        checkOutput("t3_no_0x11_frame", active, 0);

        // Test 4: asynchronous reset in the middle of bit 5 of a 0xFF frame.
        applyStimulus(0, 8'hFF);
        guard = 0;
        rises = 0;
        prev_sclk = 1'b0;
        latch_during_abort = 1'b0;
        while (rises < 5 && guard < 200) begin
            @(negedge clk);
            guard++;
            sampleOutputs(0, sclk, sdata, latch, busy, done);
            if (latch) latch_during_abort = 1'b1;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
        end
        checkOutput("t4_reach_bit5", rises, 5);
        repeat (5) begin
            @(negedge clk);
            if (bus_a.LATCH) latch_during_abort = 1'b1;
        end
        checkOutput("t4_busy_before_rst", bus_a.BUSY, 1'b1);
        #2 rst_a = 1'b1;
        #1;
        checkOutput("t4_async_outputs", {27'd0, bus_a.SCLK, bus_a.SDATA, bus_a.LATCH, bus_a.BUSY, bus_a.DONE}, 32'd0);
        checkOutput("t4_no_latch", latch_during_abort, 1'b0);
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t4_timeout", timeout, 0);
        checkOutput("t4_bits", bits, 8'hFF);
        checkOutput("t4_rises", rises, 8);
        checkOutput("t4_busy", busy_cyc, 68);
        checkOutput("t4_latch", latch_cyc, 4);

        // Test 6: 0x5A then held stable for 1000 cycles.
        repeat (3) @(negedge clk);
        applyStimulus(0, 8'h5A);
        captureFrame(0, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t6_timeout", timeout, 0);
        checkOutput("t6_bits", bits, 8'h5A);
        checkOutput("t6_done", done_seen, 1);
        idleWindow(0, 1000, active, dones);
        checkOutput("t6_stable_active", active, 0);
        checkOutput("t6_stable_done", dones, 0);

        // Test 5: LSB-first, CLK_DIV=1 instance sending 0x01.
        rst_b = 1'b0;
        captureFrame(1, bits, rises, busy_cyc, latch_cyc, hi_min, hi_max, lo_min, lo_max, done_seen, timeout);
        checkOutput("t5_timeout", timeout, 0);
        checkOutput("t5_order", bits, 8'h80);
        checkOutput("t5_rises", rises, 8);
        checkOutput("t5_busy", busy_cyc, 17);
        checkOutput("t5_latch", latch_cyc, 1);
        checkOutput("t5_hi_len", {hi_min[15:0], hi_max[15:0]}, {16'd1, 16'd1});
        checkOutput("t5_lo_len", {lo_min[15:0], lo_max[15:0]}, {16'd1, 16'd1});
        checkOutput("t5_done", done_seen, 1);
        idleWindow(1, 20, active, dones);
        checkOutput("t5_idle_active", active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
